// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: base ALU select decode plus an iterative M-extension unit
// (shift-add multiply, restoring divide; one bit per cycle).
// Build option RV_MDU_DIV_EN: when defined, the DIV state and restoring
// divider are compiled in; otherwise DIV/DIVU/REM/REMU complete at once
// with illegal=1 and result 0.
module alu_mdu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      ALUSel,
    output logic            md_sel,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            illegal
);

    // state | meaning
    // IDLE  | waiting for an M-op request
    // MUL   | shift-add multiply, one multiplier bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    // DONE  | result valid, done pulse
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef RV_MDU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam int CW = $clog2(XLEN) + 1;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] prod_q;   // mul: {acc_hi, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opnd_q;   // multiplicand or divisor magnitude
    logic [1:0]        f3_q;
    logic              neg_q;
    logic              ill_q;

    logic              accept, is_div, sign_a, sign_b, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_full;
    logic [XLEN-1:0]   mul_res;

    // Combinational ALU select and M-op detection
    always_comb begin
        md_sel = (ALUOp == 2'b10) && (funct7 == 7'b0000001);
        ALUSel = ALU_ADD;
        if (!md_sel) begin
            case (ALUOp)
                2'b00: ALUSel = ALU_ADD;
                2'b01: ALUSel = ALU_SUB;
                default: begin
                    case (funct3)
                        3'b000:  ALUSel = (ALUOp == 2'b10 && funct7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001:  ALUSel = ALU_SLL;
                        3'b010:  ALUSel = ALU_SLT;
                        3'b011:  ALUSel = ALU_SLTU;
                        3'b100:  ALUSel = ALU_XOR;
                        3'b101:  ALUSel = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  ALUSel = ALU_OR;
                        default: ALUSel = ALU_AND;
                    endcase
                end
            endcase
        end
    end

    // Request decode: operand signedness and magnitudes
    always_comb begin
        accept = (state == S_IDLE) && valid_in && md_sel;
        is_div = funct3[2];
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin sign_a = 1'b1; sign_b = 1'b1; end
            3'b010:                         begin sign_a = 1'b1; sign_b = 1'b0; end
            default:                        begin sign_a = 1'b0; sign_b = 1'b0; end
        endcase
        a_neg = sign_a && op_a[XLEN-1];
        b_neg = sign_b && op_b[XLEN-1];
        a_mag = a_neg ? (0 - op_a) : op_a;
        b_mag = b_neg ? (0 - op_b) : op_b;
    end

    // Multiply step: conditional add into the upper half, then shift right
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, prod_q[XLEN-1:1]};
        mul_full = neg_q ? (0 - mul_next) : mul_next;
        mul_res  = (f3_q == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end

`ifdef RV_MDU_DIV_EN
    logic              div_zero, div_ovf;
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   div_pick, div_res;

    // Restoring divide step plus the zero-divisor / overflow shortcuts
    always_comb begin
        div_zero  = (op_b == '0);
        div_ovf   = sign_a && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};
        div_pick  = f3_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        div_res   = neg_q ? (0 - div_pick) : div_pick;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef RV_MDU_DIV_EN
                    if (is_div) state_nxt = (div_zero || div_ovf) ? S_DONE : S_DIV;
                    else        state_nxt = S_MUL;
`else
                    state_nxt = is_div ? S_DONE : S_MUL;
`endif
                end
            end
            S_MUL:  if (cnt_q == CW'(1)) state_nxt = S_DONE;
`ifdef RV_MDU_DIV_EN
            S_DIV:  if (cnt_q == CW'(1)) state_nxt = S_DONE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        done    = (state == S_DONE);
        illegal = (state == S_DONE) && ill_q;
        stall   = accept || (state == S_MUL)
`ifdef RV_MDU_DIV_EN
                  || (state == S_DIV)
`endif
                  ;
    end

    // Datapath: operand capture, iteration, result write on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            prod_q <= '0;
            opnd_q <= '0;
            f3_q   <= '0;
            neg_q  <= 1'b0;
            ill_q  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q  <= CW'(XLEN);
                        f3_q   <= funct3[1:0];
                        ill_q  <= 1'b0;
                        neg_q  <= (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                        opnd_q <= is_div ? b_mag : a_mag;
                        prod_q <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
`ifdef RV_MDU_DIV_EN
                        // Quotient of x/0 is all ones; remainder is the dividend.
                        if (is_div && div_zero)
                            result <= funct3[1] ? op_a : '1;
                        else if (is_div && div_ovf)
                            result <= funct3[1] ? '0 : op_a;
`else
                        if (is_div) begin
                            ill_q  <= 1'b1;
                            result <= '0;
                        end
`endif
                    end
                end
                S_MUL: begin
                    prod_q <= mul_next;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) result <= mul_res;
                end
`ifdef RV_MDU_DIV_EN
                S_DIV: begin
                    prod_q <= div_next;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) result <= div_res;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed bench for alu_mdu_ctrl (XLEN=32); division checks follow the
// RV_MDU_DIV_EN build option.
module tb_alu_mdu_ctrl;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_in;
    logic [1:0]      ALUOp;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a, op_b;
    logic [3:0]      ALUSel;
    logic            md_sel, stall, done, illegal;
    logic [XLEN-1:0] result;

    int vectors = 0;
    int fails   = 0;

    localparam logic [3:0] E_ADD = 4'b0000, E_SUB = 4'b1000, E_SRA = 4'b1101,
                           E_SRL = 4'b0101, E_AND = 4'b0111, E_SLTU = 4'b0011;

    alu_mdu_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ALUOp(ALUOp),
        .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .ALUSel(ALUSel), .md_sel(md_sel), .stall(stall), .result(result),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic decode(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [3:0] exp_sel, input logic exp_md);
        ALUOp = op; funct3 = f3; funct7 = f7;
        #1;
        chk({tag, "_sel"}, 64'(ALUSel), 64'(exp_sel));
        chk({tag, "_md"},  64'(md_sel), 64'(exp_md));
    endtask

    // Issue one M-op; when hold=1 valid_in stays high with altered operands while busy.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input logic exp_ill, input bit hold);
        int  k;
        bit  got;
        @(negedge clk);
        valid_in = 1'b1; ALUOp = 2'b10; funct3 = f3; funct7 = 7'b0000001;
        op_a = a; op_b = b;
        #1 chk({tag, "_stall_req"}, 64'(stall), 64'(1'b1));
        k = 0; got = 0;
        while (!got && k < XLEN + 10) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                if (hold) begin op_a = ~a; op_b = b + 32'd1; end
                else valid_in = 1'b0;
            end
            if (done) got = 1;
        end
        valid_in = 1'b0;
        chk({tag, "_done_seen"}, 64'(got), 64'(1'b1));
        chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
        chk({tag, "_result"}, 64'(result), 64'(exp_res));
        chk({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
        chk({tag, "_stall_done"}, 64'(stall), 64'(1'b0));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'(1'b0));
        chk({tag, "_result_hold"}, 64'(result), 64'(exp_res));
    endtask

    initial begin
        int ndone;
        rst = 1'b1; valid_in = 1'b0; ALUOp = 2'b00; funct3 = 3'b000;
        funct7 = 7'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_illegal", 64'(illegal), 64'(1'b0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_stall", 64'(stall), 64'(1'b0));
        @(negedge clk);
        rst = 1'b0;

        // ALU select decode
        decode("ld_st",  2'b00, 3'b111, 7'b0100000, E_ADD,  1'b0);
        decode("branch", 2'b01, 3'b000, 7'b0000000, E_SUB,  1'b0);
        decode("i_addi", 2'b11, 3'b000, 7'b0100000, E_ADD,  1'b0);
        decode("r_sra",  2'b10, 3'b101, 7'b0100000, E_SRA,  1'b0);
        decode("i_srai", 2'b11, 3'b101, 7'b0100000, E_SRA,  1'b0);
        decode("r_srl",  2'b10, 3'b101, 7'b0000000, E_SRL,  1'b0);
        decode("r_and",  2'b10, 3'b111, 7'b0000000, E_AND,  1'b0);
        decode("r_sltu", 2'b10, 3'b011, 7'b0000000, E_SLTU, 1'b0);
        decode("m_op",   2'b10, 3'b010, 7'b0000001, E_ADD,  1'b1);

        // R-type SUB request is not an M-op: no stall, no done
        @(negedge clk);
        valid_in = 1'b1; ALUOp = 2'b10; funct3 = 3'b000; funct7 = 7'b0100000;
        #1;
        chk("sub_sel", 64'(ALUSel), 64'(E_SUB));
        chk("sub_md", 64'(md_sel), 64'(1'b0));
        chk("sub_stall", 64'(stall), 64'(1'b0));
        ndone = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done || stall) ndone++;
        end
        chk("sub_no_activity", 64'(ndone), 64'(0));
        valid_in = 1'b0;

        // Multiply
        run_op("mul",    3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, XLEN + 1, 1'b0, 0);
        run_op("mulh",   3'b001, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, XLEN + 1, 1'b0, 0);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, XLEN + 1, 1'b0, 0);
        run_op("mul_ff", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, XLEN + 1, 1'b0, 0);
        run_op("mulhsu", 3'b010, 32'd2,        32'h80000000, 32'h00000001, XLEN + 1, 1'b0, 0);
        run_op("mulhsu_n", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, XLEN + 1, 1'b0, 0);
        run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, XLEN + 1, 1'b0, 0);
        run_op("mul_hold", 3'b000, 32'h12345678, 32'h10,     32'h23456780, XLEN + 1, 1'b0, 1);

`ifdef RV_MDU_DIV_EN
        run_op("div",    3'b100, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, XLEN + 1, 1'b0, 0);
        run_op("rem",    3'b110, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, XLEN + 1, 1'b0, 0);
        run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       XLEN + 1, 1'b0, 0);
        run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        XLEN + 1, 1'b0, 0);
        run_op("divu_z", 3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, 1,        1'b0, 0);
        run_op("remu_z", 3'b111, 32'd7,        32'd0,        32'd7,        1,        1'b0, 0);
        run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,        1'b0, 0);
        run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,        1'b0, 0);
`else
        run_op("divu_ill", 3'b101, 32'd9,      32'd3,        32'd0,        1,        1'b1, 0);
        run_op("rem_ill",  3'b110, 32'hFFFFFFEC, 32'd6,      32'd0,        1,        1'b1, 0);
`endif

        // Reset during a multiply aborts it without a done pulse
        @(negedge clk);
        valid_in = 1'b1; ALUOp = 2'b10; funct3 = 3'b000; funct7 = 7'b0000001;
        op_a = 32'd5; op_b = 32'd9;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_stall", 64'(stall), 64'(1'b0));
        chk("abort_done", 64'(done), 64'(1'b0));
        chk("abort_result", 64'(result), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (XLEN + 8) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'(0));
        run_op("after_rst", 3'b000, 32'd5, 32'd9, 32'd45, XLEN + 1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
